// File: rtl/stack_ext_pkg.sv
// Shared types for the nested-context LIFO (stack_ext) and its pointer controller.
`default_nettype none

package stack_ext_pkg;

    // Behaviour when a push arrives while the stack is already full
    typedef enum logic {
        STACK_SAT,
        STACK_WRAP
    } stack_mode_t;

endpackage

`default_nettype wire

// File: rtl/stack_ptr_ctrl.sv
// Top pointer, occupancy count and sticky error flags for stack_ext.
// Pointer arithmetic is modulo StackDepth via explicit compares, so any depth works.
`default_nettype none

module stack_ptr_ctrl
    import stack_ext_pkg::*;
#(
    parameter int          StackDepth = 8,
    parameter stack_mode_t Mode       = STACK_SAT,
    localparam int         PtrWidth   = $clog2(StackDepth),
    localparam int         CntWidth   = $clog2(StackDepth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                err_clr_i,
    output logic [PtrWidth-1:0] ptr_o,
    output logic                wr_en_o,
    output logic [PtrWidth-1:0] wr_ptr_o,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam logic [PtrWidth-1:0] PtrMax  = PtrWidth'(StackDepth - 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(StackDepth);

    logic [PtrWidth-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                full, empty;

    assign full    = (cnt_q == CntFull);
    assign empty   = (cnt_q == '0);
    assign ptr_inc = (ptr_q == PtrMax) ? '0 : ptr_q + PtrWidth'(1);
    assign ptr_dec = (ptr_q == '0) ? PtrMax : ptr_q - PtrWidth'(1);

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = err_clr_i ? 1'b0 : ovf_q;
        unf_d   = err_clr_i ? 1'b0 : unf_q;
        wr_en_o = 1'b0;
        // push+pop on an empty stack falls through to the plain-push branch
        if (push_i && pop_i && !empty) begin
            wr_en_o = 1'b1;
        end else if (push_i && !full) begin
            ptr_d   = ptr_inc;
            cnt_d   = cnt_q + CntWidth'(1);
            wr_en_o = 1'b1;
        end else if (push_i) begin
            ovf_d = 1'b1;
            if (Mode == STACK_WRAP) begin
                ptr_d   = ptr_inc;
                wr_en_o = 1'b1;
            end
        end else if (pop_i && !empty) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CntWidth'(1);
        end else if (pop_i) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ptr_o       = ptr_q;
    assign wr_ptr_o    = ptr_d;
    assign count_o     = cnt_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

`default_nettype wire

// File: rtl/stack_ext.sv
// Parametrised LIFO with count, flags, replace-top and SAT/WRAP full policy.
// Optional peek port enabled by `STACK_EXT_PEEK_EN.
`default_nettype none

module stack_ext
    import stack_ext_pkg::*;
#(
    parameter int          StackDepth = 8,
    parameter int          DataWidth  = 8,
    parameter stack_mode_t Mode       = STACK_SAT,
    localparam int         PtrWidth   = $clog2(StackDepth),
    localparam int         CntWidth   = $clog2(StackDepth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] data_in,
    input  logic                 err_clr,
    output logic [DataWidth-1:0] data_out,
    output logic [CntWidth-1:0]  count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
`ifdef STACK_EXT_PEEK_EN
    ,
    input  logic [PtrWidth-1:0]  peek_idx,
    output logic [DataWidth-1:0] peek_data
`endif
);

    logic [DataWidth-1:0] mem_q [StackDepth];
    logic [PtrWidth-1:0]  ptr, wr_ptr;
    logic                 wr_en;

    stack_ptr_ctrl #(
        .StackDepth (StackDepth),
        .Mode       (Mode)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .err_clr_i   (err_clr),
        .ptr_o       (ptr),
        .wr_en_o     (wr_en),
        .wr_ptr_o    (wr_ptr),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    // Storage is deliberately not reset; writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    assign data_out = empty ? '0 : mem_q[ptr];

`ifdef STACK_EXT_PEEK_EN
    logic [PtrWidth-1:0] peek_addr;

    always_comb begin
        if (ptr >= peek_idx) begin
            peek_addr = ptr - peek_idx;
        end else begin
            peek_addr = PtrWidth'({1'b0, ptr} + (PtrWidth + 1)'(StackDepth) - {1'b0, peek_idx});
        end
    end

    assign peek_data = (CntWidth'(peek_idx) >= count) ? '0 : mem_q[peek_addr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_ext.sv
// Bench for stack_ext: SAT and WRAP instances driven in lockstep against a list model.
`default_nettype none

module tb_stack_ext;
    import stack_ext_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [7:0] data_in = 8'h0;
    logic [1:0] peek_idx = 2'd0;

    logic [7:0] dout_s, dout_w, pk_s, pk_w;
    logic [2:0] cnt_s, cnt_w;
    logic       full_s, full_w, empty_s, empty_w, ovf_s, ovf_w, unf_s, unf_w;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: index 0 = oldest entry, msize-1 = top
    logic [7:0] mdata [2][4];
    int         msize [2];
    bit         mo [2];
    bit         mu [2];

    always #5 clk = ~clk;

    stack_ext #(.StackDepth(4), .DataWidth(8), .Mode(STACK_SAT)) dut_sat (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .err_clr(err_clr), .data_out(dout_s), .count(cnt_s), .full(full_s),
        .empty(empty_s), .overflow(ovf_s), .underflow(unf_s)
`ifdef STACK_EXT_PEEK_EN
        , .peek_idx(peek_idx), .peek_data(pk_s)
`endif
    );

    stack_ext #(.StackDepth(4), .DataWidth(8), .Mode(STACK_WRAP)) dut_wrap (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .err_clr(err_clr), .data_out(dout_w), .count(cnt_w), .full(full_w),
        .empty(empty_w), .overflow(ovf_w), .underflow(unf_w)
`ifdef STACK_EXT_PEEK_EN
        , .peek_idx(peek_idx), .peek_data(pk_w)
`endif
    );

`ifndef STACK_EXT_PEEK_EN
    assign pk_s = 8'h0;
    assign pk_w = 8'h0;
`endif

    function automatic logic [22:0] got_vec(int m);
        if (m == 0) return {cnt_s, full_s, empty_s, ovf_s, unf_s, dout_s, pk_s};
        return {cnt_w, full_w, empty_w, ovf_w, unf_w, dout_w, pk_w};
    endfunction

    function automatic logic [22:0] exp_vec(int m);
        int         n = msize[m];
        logic [7:0] top = (n > 0) ? mdata[m][n-1] : 8'h0;
        logic [7:0] pk = 8'h0;
`ifdef STACK_EXT_PEEK_EN
        if (int'(peek_idx) < n) pk = mdata[m][n-1-int'(peek_idx)];
`endif
        return {3'(n), n == 4, n == 0, mo[m], mu[m], top, pk};
    endfunction

    task automatic model_apply(int m, bit ps, bit pp, logic [7:0] d, bit clr);
        int n = msize[m];
        bit eo = 1'b0, eu = 1'b0;
        if (ps && pp && n > 0) mdata[m][n-1] = d;
        else if (ps && n < 4) begin mdata[m][n] = d; msize[m] = n + 1; end
        else if (ps) begin
            eo = 1'b1;
            if (m == 1) begin
                for (int i = 0; i < 3; i++) mdata[m][i] = mdata[m][i+1];
                mdata[m][3] = d;
            end
        end
        else if (pp && n > 0) msize[m] = n - 1;
        else if (pp) eu = 1'b1;
        mo[m] = eo | (mo[m] & ~clr);
        mu[m] = eu | (mu[m] & ~clr);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin msize[m] = 0; mo[m] = 0; mu[m] = 0; end
    endtask

    task automatic cycle(bit ps, bit pp, logic [7:0] d, bit clr);
        push = ps; pop = pp; data_in = d; err_clr = clr;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) model_apply(m, ps, pp, d, clr);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h expected %h", m, got_vec(m), exp_vec(m));
            end
        end
        reset = 1'b1;
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h00, 0);  // underflow set, must be cleared by reset
        push = 1'b1; data_in = 8'h33;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        push = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL reset_midpush[%0d]: got %h expected %h", m, got_vec(m), exp_vec(m));
            end
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) cycle(1, 0, vals[k], 0);
            else       cycle(0, 1, 8'h00, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL fill_drain[%0d] step %0d: got %h expected %h", m, k, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_full_policy();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 0, 8'h11 * 8'(k + 1), 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) cycle(1, 0, 8'h55, 0);
            else        cycle(0, 1, 8'h00, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL full_policy[%0d] step %0d: got %h expected %h", m, k, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_replace();
        do_reset();
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 1, 8'h99, 0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL replace_top[%0d]: got %h expected %h", m, got_vec(m), exp_vec(m));
            end
        end
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(1, 1, 8'h77, 0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL replace_empty[%0d]: got %h expected %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_errors_peek();
        do_reset();
        cycle(0, 1, 8'h00, 0);  // underflow
        cycle(0, 1, 8'h00, 1);  // clear with fresh error: set wins
        cycle(0, 0, 8'h00, 0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL err_set_wins[%0d]: got %h expected %h", m, got_vec(m), exp_vec(m));
            end
        end
        cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 0, 8'h33, 0);
        for (int p = 0; p < 4; p++) begin
            peek_idx = 2'(p);
            #1;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL err_clr_peek[%0d] idx %0d: got %h expected %h", m, p, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            peek_idx = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), ($urandom_range(0, 7) == 0));
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL random[%0d] cycle %0d: got %h expected %h", m, k, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_fill_drain();
        test_full_policy();
        test_replace();
        test_errors_peek();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
